// File: rtl/sc_pose_pkg.sv
// Shared definitions for the pose integrator: angle constants in Q15,
// FSM state encoding and signed-magnitude <-> two's complement helpers.
package sc_pose_pkg;

    localparam logic signed [31:0] TWO_PI_Q15        = 32'sd205887;
    localparam logic signed [31:0] PI_Q15            = 32'sd102944;
    localparam logic signed [31:0] HALF_PI_Q15       = 32'sd51472;
    localparam logic signed [31:0] THREE_HALF_PI_Q15 = 32'sd154416;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_X = 3'd1,
        ST_MUL_Y = 3'd2,
        ST_MUL_W = 3'd3,
        ST_WRAP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Negative zero (0x80000000) maps to plain 0.
    function automatic logic signed [31:0] sm_to_tc(input logic [31:0] sm);
        logic signed [31:0] mag;
        mag = $signed({1'b0, sm[30:0]});
        if (sm[31]) begin
            sm_to_tc = -mag;
        end else begin
            sm_to_tc = mag;
        end
    endfunction

    // Input is bounded to +/-0x7FFFFFFF, so negation never overflows;
    // zero always comes out as 0x00000000.
    function automatic logic [31:0] tc_to_sm(input logic signed [31:0] tc);
        logic signed [31:0] neg;
        neg = -tc;
        if (tc < 32'sd0) begin
            tc_to_sm = {1'b1, neg[30:0]};
        end else begin
            tc_to_sm = $unsigned(tc);
        end
    endfunction

endpackage

// File: rtl/sc_sm_mulshift.sv
// Combinational v*dt >> Q. The multiply is done on magnitudes so the
// shift truncates toward zero, then the sign of v is restored.
module sc_sm_mulshift #(
    parameter int N_WIDTH = 32,
    parameter int Q_WIDTH = 15
) (
    input  logic signed [N_WIDTH-1:0]   v_i,
    input  logic        [N_WIDTH-2:0]   dt_i,
    output logic signed [2*N_WIDTH-1:0] p_o
);
    logic [N_WIDTH-1:0]   v_mag_s;
    logic [2*N_WIDTH-1:0] prod_s;
    logic [2*N_WIDTH-1:0] shr_s;

    // magnitude multiply, shift, re-apply sign
    always_comb begin
        if (v_i[N_WIDTH-1]) begin
            v_mag_s = $unsigned(-v_i);
        end else begin
            v_mag_s = $unsigned(v_i);
        end
        prod_s = {{N_WIDTH{1'b0}}, v_mag_s} * {{(N_WIDTH+1){1'b0}}, dt_i};
        shr_s  = prod_s >> Q_WIDTH;
        if (v_i[N_WIDTH-1]) begin
            p_o = -$signed(shr_s);
        end else begin
            p_o = $signed(shr_s);
        end
    end

endmodule

// File: rtl/sc_pose_integrator.sv
// Pose integrator: x += vx*dt, y += vy*dt, theta = wrap(theta + wz*dt)
// using one shared multiplier over a fixed 5-cycle update.
// Optional quadrant fold of theta: define SC_POSE_INTEGRATOR_QUADRANT_FOLD_EN.
module sc_pose_integrator
    import sc_pose_pkg::*;
#(
    parameter int N_WIDTH = 32,
    parameter int Q_WIDTH = 15
) (
    input  logic               SC_POSE_INTEGRATOR_CLOCK_50,
    input  logic               SC_POSE_INTEGRATOR_RESET_InLow,
    input  logic               SC_POSE_INTEGRATOR_VALID_In,
    input  logic               SC_POSE_INTEGRATOR_CLEAR_In,
    input  logic [N_WIDTH-1:0] SC_POSE_INTEGRATOR_VX_InBus,
    input  logic [N_WIDTH-1:0] SC_POSE_INTEGRATOR_VY_InBus,
    input  logic [N_WIDTH-1:0] SC_POSE_INTEGRATOR_WZ_InBus,
    input  logic [N_WIDTH-1:0] SC_POSE_INTEGRATOR_DT_InBus,
    output logic [N_WIDTH-1:0] SC_POSE_INTEGRATOR_X_OutBus,
    output logic [N_WIDTH-1:0] SC_POSE_INTEGRATOR_Y_OutBus,
    output logic [N_WIDTH-1:0] SC_POSE_INTEGRATOR_THETA_OutBus,
    output logic [N_WIDTH-1:0] SC_POSE_INTEGRATOR_THETA_FOLD_OutBus,
    output logic [1:0]         SC_POSE_INTEGRATOR_QUADRANT_OutBus,
    output logic               SC_POSE_INTEGRATOR_BUSY_Out,
    output logic               SC_POSE_INTEGRATOR_DONE_Out,
    output logic               SC_POSE_INTEGRATOR_OVERFLOW_Out
);
    localparam logic signed [2*N_WIDTH-1:0] SAT_MAX   = {{(N_WIDTH+1){1'b0}}, {(N_WIDTH-1){1'b1}}};
    localparam logic signed [2*N_WIDTH-1:0] SAT_MIN   = -SAT_MAX;
    localparam logic signed [2*N_WIDTH-1:0] TWO_PI_W  = {{N_WIDTH{1'b0}}, TWO_PI_Q15};

    state_e state_q, state_d;
    logic busy_d, done_d;

    logic signed [N_WIDTH-1:0]   vx_q, vy_q, wz_q;
    logic        [N_WIDTH-2:0]   dt_q;
    logic signed [N_WIDTH-1:0]   x_acc_q, y_acc_q, th_acc_q;
    logic signed [2*N_WIDTH-1:0] th_raw_q;
    logic                        ovf_acc_q, pend_q, pend_d;
    logic [N_WIDTH-1:0]          x_q, y_q, th_q, fold_q;
    logic [1:0]                  quad_q;
    logic                        busy_q, done_q, ovf_q;

    logic signed [N_WIDTH-1:0]   mul_op_s, acc_sel_s, sat_s, th_wrap_n_s;
    logic signed [2*N_WIDTH-1:0] prod_s, sum_s, th_raw_d, th_wrap_s;
    logic                        sat_ovf_s;
    logic [N_WIDTH-1:0]          fold_s;
    logic [1:0]                  quad_s;
    logic                        accept_s, clr_idle_s, discard_s;
    logic                        unused_s;

    assign unused_s = ^{SC_POSE_INTEGRATOR_DT_InBus[N_WIDTH-1], th_wrap_s[2*N_WIDTH-1:N_WIDTH]};

    assign accept_s   = (state_q == ST_IDLE) && SC_POSE_INTEGRATOR_VALID_In
                        && !SC_POSE_INTEGRATOR_CLEAR_In && !pend_q;
    assign clr_idle_s = (state_q == ST_IDLE) && (SC_POSE_INTEGRATOR_CLEAR_In || pend_q);
    assign discard_s  = (state_q == ST_WRAP) && (SC_POSE_INTEGRATOR_CLEAR_In || pend_q);

    sc_sm_mulshift #(.N_WIDTH(N_WIDTH), .Q_WIDTH(Q_WIDTH)) u_mul (
        .v_i  (mul_op_s),
        .dt_i (dt_q),
        .p_o  (prod_s)
    );

    // operand mux, saturating x/y add and theta wrap
    always_comb begin
        case (state_q)
            ST_MUL_X: mul_op_s = vx_q;
            ST_MUL_Y: mul_op_s = vy_q;
            ST_MUL_W: mul_op_s = wz_q;
            default:  mul_op_s = {N_WIDTH{1'b0}};
        endcase
        if (state_q == ST_MUL_Y) begin
            acc_sel_s = y_acc_q;
        end else begin
            acc_sel_s = x_acc_q;
        end
        sum_s = {{N_WIDTH{acc_sel_s[N_WIDTH-1]}}, acc_sel_s} + prod_s;
        if (sum_s > SAT_MAX) begin
            sat_s     = SAT_MAX[N_WIDTH-1:0];
            sat_ovf_s = 1'b1;
        end else if (sum_s < SAT_MIN) begin
            sat_s     = SAT_MIN[N_WIDTH-1:0];
            sat_ovf_s = 1'b1;
        end else begin
            sat_s     = sum_s[N_WIDTH-1:0];
            sat_ovf_s = 1'b0;
        end
        th_raw_d = {{N_WIDTH{th_acc_q[N_WIDTH-1]}}, th_acc_q} + prod_s;
        if (th_raw_q[2*N_WIDTH-1]) begin
            th_wrap_s = th_raw_q + TWO_PI_W;
        end else if (th_raw_q >= TWO_PI_W) begin
            th_wrap_s = th_raw_q - TWO_PI_W;
        end else begin
            th_wrap_s = th_raw_q;
        end
        th_wrap_n_s = th_wrap_s[N_WIDTH-1:0];
    end

`ifdef SC_POSE_INTEGRATOR_QUADRANT_FOLD_EN
    // quadrant classification and fold of the wrapped theta
    always_comb begin
        if (th_wrap_n_s < HALF_PI_Q15) begin
            quad_s = 2'd0;
            fold_s = $unsigned(th_wrap_n_s);
        end else if (th_wrap_n_s < PI_Q15) begin
            quad_s = 2'd1;
            fold_s = $unsigned(th_wrap_n_s - HALF_PI_Q15);
        end else if (th_wrap_n_s < THREE_HALF_PI_Q15) begin
            quad_s = 2'd2;
            fold_s = $unsigned(th_wrap_n_s - PI_Q15);
        end else begin
            quad_s = 2'd3;
            fold_s = $unsigned(th_wrap_n_s - THREE_HALF_PI_Q15);
        end
    end
`else
    assign quad_s = 2'd0;
    assign fold_s = {N_WIDTH{1'b0}};
`endif

    // FSM state register
    always_ff @(posedge SC_POSE_INTEGRATOR_CLOCK_50 or negedge SC_POSE_INTEGRATOR_RESET_InLow) begin
        if (!SC_POSE_INTEGRATOR_RESET_InLow) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fixed walk through the three multiplies, wrap and done
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = accept_s ? ST_MUL_X : ST_IDLE;
            ST_MUL_X: state_d = ST_MUL_Y;
            ST_MUL_Y: state_d = ST_MUL_W;
            ST_MUL_W: state_d = ST_WRAP;
            ST_WRAP:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and pending-clear tracking, computed one state ahead so they register cleanly
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (clr_idle_s || (state_q == ST_WRAP)) begin
            pend_d = 1'b0;
        end else if ((state_q != ST_IDLE) && SC_POSE_INTEGRATOR_CLEAR_In) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // datapath: sample latch, accumulators and output registers
    always_ff @(posedge SC_POSE_INTEGRATOR_CLOCK_50 or negedge SC_POSE_INTEGRATOR_RESET_InLow) begin
        if (!SC_POSE_INTEGRATOR_RESET_InLow) begin
            vx_q <= '0; vy_q <= '0; wz_q <= '0; dt_q <= '0;
            x_acc_q <= '0; y_acc_q <= '0; th_acc_q <= '0; th_raw_q <= '0;
            ovf_acc_q <= 1'b0; pend_q <= 1'b0;
            x_q <= '0; y_q <= '0; th_q <= '0; fold_q <= '0; quad_q <= 2'd0;
            busy_q <= 1'b0; done_q <= 1'b0; ovf_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            pend_q <= pend_d;
            if (clr_idle_s || discard_s) begin
                x_acc_q <= '0; y_acc_q <= '0; th_acc_q <= '0; th_raw_q <= '0;
                ovf_acc_q <= 1'b0;
                x_q <= '0; y_q <= '0; th_q <= '0; fold_q <= '0; quad_q <= 2'd0;
                ovf_q <= 1'b0;
            end else begin
                if (accept_s) begin
                    vx_q <= sm_to_tc(SC_POSE_INTEGRATOR_VX_InBus);
                    vy_q <= sm_to_tc(SC_POSE_INTEGRATOR_VY_InBus);
                    wz_q <= sm_to_tc(SC_POSE_INTEGRATOR_WZ_InBus);
                    dt_q <= SC_POSE_INTEGRATOR_DT_InBus[N_WIDTH-2:0];
                end
                if (state_q == ST_MUL_X) begin
                    x_acc_q   <= sat_s;
                    ovf_acc_q <= ovf_acc_q | sat_ovf_s;
                end
                if (state_q == ST_MUL_Y) begin
                    y_acc_q   <= sat_s;
                    ovf_acc_q <= ovf_acc_q | sat_ovf_s;
                end
                if (state_q == ST_MUL_W) begin
                    th_raw_q <= th_raw_d;
                end
                if (state_q == ST_WRAP) begin
                    th_acc_q <= th_wrap_n_s;
                    x_q      <= tc_to_sm(x_acc_q);
                    y_q      <= tc_to_sm(y_acc_q);
                    th_q     <= tc_to_sm(th_wrap_n_s);
                    fold_q   <= fold_s;
                    quad_q   <= quad_s;
                    ovf_q    <= ovf_acc_q;
                end
            end
        end
    end

    assign SC_POSE_INTEGRATOR_X_OutBus          = x_q;
    assign SC_POSE_INTEGRATOR_Y_OutBus          = y_q;
    assign SC_POSE_INTEGRATOR_THETA_OutBus      = th_q;
    assign SC_POSE_INTEGRATOR_THETA_FOLD_OutBus = fold_q;
    assign SC_POSE_INTEGRATOR_QUADRANT_OutBus   = quad_q;
    assign SC_POSE_INTEGRATOR_BUSY_Out          = busy_q;
    assign SC_POSE_INTEGRATOR_DONE_Out          = done_q;
    assign SC_POSE_INTEGRATOR_OVERFLOW_Out      = ovf_q;

endmodule

// File: tb/tb_sc_pose_integrator.sv
// Self-checking bench for sc_pose_integrator: a vector table drives updates,
// expected poses go into a scoreboard queue and are popped on each DONE pulse.
module tb_sc_pose_integrator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] vx = 32'd0, vy = 32'd0, wz = 32'd0, dt = 32'd0;
    logic [31:0] x_o, y_o, th_o, fold_o;
    logic [1:0]  quad_o;
    logic        busy_o, done_o, ovf_o;

    typedef struct {
        logic [31:0] vx, vy, wz, dt;
        logic [31:0] ex, ey, eth;
        logic        eovf;
        logic [1:0]  eq;
        logic [31:0] ef;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[11];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   d0;

    always #10 clk = ~clk;

    sc_pose_integrator dut (
        .SC_POSE_INTEGRATOR_CLOCK_50          (clk),
        .SC_POSE_INTEGRATOR_RESET_InLow       (rst_n),
        .SC_POSE_INTEGRATOR_VALID_In          (valid),
        .SC_POSE_INTEGRATOR_CLEAR_In          (clear),
        .SC_POSE_INTEGRATOR_VX_InBus          (vx),
        .SC_POSE_INTEGRATOR_VY_InBus          (vy),
        .SC_POSE_INTEGRATOR_WZ_InBus          (wz),
        .SC_POSE_INTEGRATOR_DT_InBus          (dt),
        .SC_POSE_INTEGRATOR_X_OutBus          (x_o),
        .SC_POSE_INTEGRATOR_Y_OutBus          (y_o),
        .SC_POSE_INTEGRATOR_THETA_OutBus      (th_o),
        .SC_POSE_INTEGRATOR_THETA_FOLD_OutBus (fold_o),
        .SC_POSE_INTEGRATOR_QUADRANT_OutBus   (quad_o),
        .SC_POSE_INTEGRATOR_BUSY_Out          (busy_o),
        .SC_POSE_INTEGRATOR_DONE_Out          (done_o),
        .SC_POSE_INTEGRATOR_OVERFLOW_Out      (ovf_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] vx_v, vy_v, wz_v, dt_v, ex, ey, eth,
                                input logic eovf, input logic [1:0] eq, input logic [31:0] ef);
        vec_t v;
        v.vx = vx_v; v.vy = vy_v; v.wz = wz_v; v.dt = dt_v;
        v.ex = ex; v.ey = ey; v.eth = eth; v.eovf = eovf; v.eq = eq; v.ef = ef;
        return v;
    endfunction

    // scoreboard: every DONE pulse must match the oldest expected pose
    always @(negedge clk) begin : monitor
        vec_t e;
        if (done_o === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got DONE with empty scoreboard at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("x", x_o, e.ex);
                chk("y", y_o, e.ey);
                chk("theta", th_o, e.eth);
                chk("overflow", {31'd0, ovf_o}, {31'd0, e.eovf});
`ifdef SC_POSE_INTEGRATOR_QUADRANT_FOLD_EN
                chk("quadrant", {30'd0, quad_o}, {30'd0, e.eq});
                chk("theta_fold", fold_o, e.ef);
`else
                chk("quadrant", {30'd0, quad_o}, 32'd0);
                chk("theta_fold", fold_o, 32'd0);
`endif
            end
        end
    end

    task automatic drive(input logic [31:0] a, b, c, d);
        vx = a; vy = b; wz = c; dt = d;
    endtask

    // one full update: push expectation, pulse VALID, check latency and busy length
    task automatic do_update(input vec_t v);
        int busy_n;
        int done_at;
        sb_q.push_back(v);
        @(negedge clk);
        drive(v.vx, v.vy, v.wz, v.dt);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        busy_n  = 0;
        done_at = -1;
        for (int i = 0; i < 8; i++) begin
            if (busy_o === 1'b1) busy_n++;
            if (done_o === 1'b1 && done_at < 0) done_at = i;
            @(negedge clk);
        end
        chk("done_latency", done_at, 32'd4);
        chk("busy_cycles", busy_n, 32'd5);
    endtask

    initial begin
        tbl[0]  = mk(32'h00008000, 32'h0, 32'h0, 32'h00004000, 32'h00004000, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0);
        tbl[1]  = mk(32'h00008000, 32'h0, 32'h0, 32'h00004000, 32'h00008000, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0);
        tbl[2]  = mk(32'h0, 32'h80008000, 32'h0, 32'h00004000, 32'h00008000, 32'h80004000, 32'h0, 1'b0, 2'd0, 32'd0);
        tbl[3]  = mk(32'h0, 32'h00004000, 32'h0, 32'h00008000, 32'h00008000, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0);
        tbl[4]  = mk(32'h0, 32'h0, 32'h80002000, 32'h00008000, 32'h00008000, 32'h0, 32'h0003043F, 1'b0, 2'd3, 32'd43279);
        tbl[5]  = mk(32'h0, 32'h0, 32'h00002000, 32'h00008000, 32'h00008000, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0);
        tbl[6]  = mk(32'h0, 32'h0, 32'h00010000, 32'h00008000, 32'h00008000, 32'h0, 32'h00010000, 1'b0, 2'd1, 32'd14064);
        tbl[7]  = mk(32'h80000000, 32'h80000000, 32'h80000000, 32'h00007FFF, 32'h00008000, 32'h0, 32'h00010000, 1'b0, 2'd1, 32'd14064);
        tbl[8]  = mk(32'h00008000, 32'h0, 32'h0, 32'h80008000, 32'h00010000, 32'h0, 32'h00010000, 1'b0, 2'd1, 32'd14064);
        tbl[9]  = mk(32'h00000003, 32'h80000001, 32'h0, 32'h00004000, 32'h00010001, 32'h0, 32'h00010000, 1'b0, 2'd1, 32'd14064);
        tbl[10] = mk(32'h0, 32'h0, 32'h80010000, 32'h00004000, 32'h00010001, 32'h0, 32'h00008000, 1'b0, 2'd0, 32'd32768);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_x", x_o, 32'd0);
        chk("rst_theta", th_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) do_update(tbl[i]);

        // second VALID two edges into an update is ignored
        d0 = done_cnt;
        sb_q.push_back(mk(32'h00008000, 32'h0, 32'h0, 32'h00008000, 32'h00018001, 32'h0, 32'h00008000, 1'b0, 2'd0, 32'd32768));
        @(negedge clk); drive(32'h00008000, 32'h0, 32'h0, 32'h00008000); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        @(negedge clk); drive(32'h00012345, 32'h0, 32'h0, 32'h00008000); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("single_done", done_cnt - d0, 32'd1);

        // reset in the middle of an update: abandoned, no DONE
        d0 = done_cnt;
        @(negedge clk); drive(32'h00008000, 32'h0, 32'h0, 32'h00008000); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst_x", x_o, 32'd0);
        chk("midrst_theta", th_o, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 32'd0);
        do_update(mk(32'h00008000, 32'h0, 32'h0, 32'h00004000, 32'h00004000, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0));

        // CLEAR one edge into an update: DONE still pulses with a zeroed pose
        d0 = done_cnt;
        sb_q.push_back(mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0));
        @(negedge clk); drive(32'h00008000, 32'h00008000, 32'h00001000, 32'h00008000); valid = 1'b1;
        @(negedge clk); valid = 1'b0; clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        repeat (7) @(negedge clk);
        chk("clr_busy_done", done_cnt - d0, 32'd1);

        // saturation of x, sticky overflow
        do_update(mk(32'h7FFFFFFF, 32'h0, 32'h0, 32'h00008000, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0));
        do_update(mk(32'h7FFFFFFF, 32'h0, 32'h0, 32'h00008000, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b1, 2'd0, 32'd0));
        do_update(mk(32'h7FFFFFFF, 32'h0, 32'h0, 32'h00008000, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b1, 2'd0, 32'd0));

        // CLEAR in IDLE: pose and overflow zeroed, no DONE
        d0 = done_cnt;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        @(negedge clk);
        chk("idle_clr_x", x_o, 32'd0);
        chk("idle_clr_ovf", {31'd0, ovf_o}, 32'd0);
        chk("idle_clr_no_done", done_cnt - d0, 32'd0);

        // CLEAR and VALID together: VALID dropped
        d0 = done_cnt;
        @(negedge clk); drive(32'h00008000, 32'h0, 32'h0, 32'h00008000); clear = 1'b1; valid = 1'b1;
        @(negedge clk); clear = 1'b0; valid = 1'b0;
        chk("clr_valid_busy", {31'd0, busy_o}, 32'd0);
        repeat (7) @(negedge clk);
        chk("clr_valid_no_done", done_cnt - d0, 32'd0);
        chk("clr_valid_x", x_o, 32'd0);

        do_update(mk(32'h00008000, 32'h0, 32'h0, 32'h00008000, 32'h00008000, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0));

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
